// File: rtl/fifo_pkg.sv
// Shared constants and FSM encoding for the FIFO drain-side packer.
package fifo_pkg;
   localparam int FIFO_WIDTH_DEF = 16;

   typedef enum logic [2:0] {
      S_EMPTY   = 3'd0,
      S_LO_WAIT = 3'd1,
      S_HALF    = 3'd2,
      S_HI_WAIT = 3'd3,
      S_OUT     = 3'd4
   } packer_state_e;
endpackage

// File: rtl/sat_counter.sv
// Saturating up-counter: increments once per cycle with inc high, holds at all-ones.
module sat_counter #(
   parameter int W = 8
) (
   input  logic         clk,
   input  logic         rst_n,
   input  logic         inc,
   output logic [W-1:0] cnt
);
   logic [W-1:0] cnt_q, cnt_d;

   always_comb begin
      cnt_d = cnt_q;
      if (inc && (cnt_q != {W{1'b1}})) cnt_d = cnt_q + 1'b1;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) cnt_q <= '0;
      else        cnt_q <= cnt_d;
   end

   assign cnt = cnt_q;
endmodule

// File: rtl/fifo_rd_packer.sv
// Drains a 1-cycle-latency FIFO, packing word pairs {hi, lo} onto a valid/ready port.
// Optional PACKER_PARITY_EN adds a registered m_parity = ^m_data output.
module fifo_rd_packer
   import fifo_pkg::*;
#(
   parameter int FIFO_WIDTH = FIFO_WIDTH_DEF,
   parameter int ERR_CNT_W  = 8
) (
   input  logic                    clk,
   input  logic                    rst_n,
   output logic                    fifo_rd_en,
   input  logic [FIFO_WIDTH-1:0]   fifo_data_out,
   input  logic                    fifo_empty,
   input  logic                    fifo_underflow,
   input  logic                    flush,
   output logic [2*FIFO_WIDTH-1:0] m_data,
   output logic                    m_valid,
   output logic                    m_half,
   input  logic                    m_ready,
   output logic [ERR_CNT_W-1:0]    err_cnt
`ifdef PACKER_PARITY_EN
   ,output logic                   m_parity
`endif
);
   localparam int OUT_WIDTH = 2 * FIFO_WIDTH;

   packer_state_e          state_q, state_d;
   logic [FIFO_WIDTH-1:0]  lo_q, lo_d;
   logic [OUT_WIDTH-1:0]   m_data_q, m_data_d;
   logic                   m_valid_q, m_valid_d;
   logic                   m_half_q, m_half_d;
   logic                   rd_en;

   // Read strobe is decoded from the current state so returned data lines up
   // with the wait state one cycle later.
   always_comb begin
      state_d   = state_q;
      lo_d      = lo_q;
      m_data_d  = m_data_q;
      m_valid_d = m_valid_q;
      m_half_d  = m_half_q;
      rd_en     = 1'b0;
      case (state_q)
         S_EMPTY: begin
            if (!fifo_empty) begin
               rd_en   = 1'b1;
               state_d = S_LO_WAIT;
            end
         end
         S_LO_WAIT: begin
            if (fifo_underflow) begin
               state_d = S_EMPTY;
            end else begin
               lo_d = fifo_data_out;
               if (!fifo_empty) begin
                  rd_en   = 1'b1;
                  state_d = S_HI_WAIT;
               end else begin
                  state_d = S_HALF;
               end
            end
         end
         S_HALF: begin
            if (!fifo_empty) begin
               rd_en   = 1'b1;
               state_d = S_HI_WAIT;
            end else if (flush) begin
               m_data_d  = {{FIFO_WIDTH{1'b0}}, lo_q};
               m_half_d  = 1'b1;
               m_valid_d = 1'b1;
               state_d   = S_OUT;
            end
         end
         S_HI_WAIT: begin
            if (fifo_underflow) begin
               state_d = S_HALF;
            end else begin
               m_data_d  = {fifo_data_out, lo_q};
               m_half_d  = 1'b0;
               m_valid_d = 1'b1;
               state_d   = S_OUT;
            end
         end
         S_OUT: begin
            if (m_ready) begin
               m_valid_d = 1'b0;
               if (!fifo_empty) begin
                  rd_en   = 1'b1;
                  state_d = S_LO_WAIT;
               end else begin
                  state_d = S_EMPTY;
               end
            end
         end
         default: state_d = S_EMPTY;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q   <= S_EMPTY;
         lo_q      <= '0;
         m_data_q  <= '0;
         m_valid_q <= 1'b0;
         m_half_q  <= 1'b0;
      end else begin
         state_q   <= state_d;
         lo_q      <= lo_d;
         m_data_q  <= m_data_d;
         m_valid_q <= m_valid_d;
         m_half_q  <= m_half_d;
      end
   end

   // Keep the strobe quiet while reset is held, even if the FIFO is not empty.
   assign fifo_rd_en = rd_en & rst_n;
   assign m_data     = m_data_q;
   assign m_valid    = m_valid_q;
   assign m_half     = m_half_q;

`ifdef PACKER_PARITY_EN
   logic parity_q;
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) parity_q <= 1'b0;
      else        parity_q <= ^m_data_d;
   end
   assign m_parity = parity_q;
`endif

   sat_counter #(.W(ERR_CNT_W)) u_err_cnt (
      .clk   (clk),
      .rst_n (rst_n),
      .inc   (fifo_underflow),
      .cnt   (err_cnt)
   );
endmodule

// File: tb/tb_fifo_rd_packer.sv
// Directed bench for fifo_rd_packer with a small behavioural FIFO in front of it.
module tb_fifo_rd_packer;
   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic        fifo_rd_en;
   logic [15:0] fifo_data_out = 16'h0;
   logic        fifo_empty;
   logic        fifo_underflow;
   logic        flush = 1'b0;
   logic [31:0] m_data;
   logic        m_valid;
   logic        m_half;
   logic        m_ready = 1'b1;
   logic [7:0]  err_cnt;
`ifdef PACKER_PARITY_EN
   logic        m_parity;
`endif

   int checks = 0;
   int errors = 0;

   logic [15:0] mem [0:255];
   int          wp = 0;
   int          rp = 0;
   int          rd_count = 0;
   int          uf_at_read = -1;
   logic        uf_q = 1'b0;
   logic        uf_man = 1'b0;

   int          beats = 0;
   logic [31:0] last_data = 32'h0;
   logic        last_half = 1'b0;

   always #5 clk = ~clk;

   assign fifo_empty     = (wp == rp);
   assign fifo_underflow = uf_q | uf_man;

   always @(posedge clk) begin
      uf_q <= fifo_rd_en && (rd_count == uf_at_read);
      if (fifo_rd_en) begin
         fifo_data_out <= mem[rp];
         rp            <= rp + 1;
         rd_count      <= rd_count + 1;
      end
   end

   always @(posedge clk) begin
      if (rst_n && m_valid && m_ready) begin
         beats     <= beats + 1;
         last_data <= m_data;
         last_half <= m_half;
      end
   end

   fifo_rd_packer #(.FIFO_WIDTH(16), .ERR_CNT_W(8)) dut (
      .clk            (clk),
      .rst_n          (rst_n),
      .fifo_rd_en     (fifo_rd_en),
      .fifo_data_out  (fifo_data_out),
      .fifo_empty     (fifo_empty),
      .fifo_underflow (fifo_underflow),
      .flush          (flush),
      .m_data         (m_data),
      .m_valid        (m_valid),
      .m_half         (m_half),
      .m_ready        (m_ready),
      .err_cnt        (err_cnt)
`ifdef PACKER_PARITY_EN
      ,.m_parity      (m_parity)
`endif
   );

   task automatic push(input logic [15:0] w);
      mem[wp] = w;
      wp = wp + 1;
   endtask

   task automatic wait_beat(input int b0, input string nm);
      int k = 0;
      while (beats == b0 && k < 50) begin
         @(negedge clk);
         k++;
      end
      if (beats == b0) begin
         checks++;
         errors++;
         $display("FAIL %s timeout: beats=%0d required>%0d", nm, beats, b0);
      end
   endtask

   task automatic pulse_flush();
      flush = 1'b1;
      @(negedge clk);
      flush = 1'b0;
   endtask

   task automatic test_reset();
      rst_n = 1'b0;
      repeat (3) @(negedge clk);
      checks += 5;
      if (fifo_rd_en !== 1'b0) begin errors++; $display("FAIL rst_rd_en got=%b exp=0", fifo_rd_en); end
      if (m_valid !== 1'b0)    begin errors++; $display("FAIL rst_valid got=%b exp=0", m_valid); end
      if (m_half !== 1'b0)     begin errors++; $display("FAIL rst_half got=%b exp=0", m_half); end
      if (m_data !== 32'h0)    begin errors++; $display("FAIL rst_data got=%h exp=0", m_data); end
      if (err_cnt !== 8'h0)    begin errors++; $display("FAIL rst_err got=%0d exp=0", err_cnt); end
      rst_n = 1'b1;
      @(negedge clk);
   endtask

   task automatic test_basic();
      int b0 = beats;
      int r0 = rd_count;
      m_ready = 1'b1;
      push(16'hAAAA);
      push(16'h5555);
      wait_beat(b0, "basic");
      repeat (3) @(negedge clk);
      checks += 4;
      if (last_data !== 32'h5555_AAAA) begin errors++; $display("FAIL basic_data got=%h exp=5555aaaa", last_data); end
      if (last_half !== 1'b0)          begin errors++; $display("FAIL basic_half got=%b exp=0", last_half); end
      if (beats != b0 + 1)             begin errors++; $display("FAIL basic_beats got=%0d exp=%0d", beats, b0 + 1); end
      if (rd_count != r0 + 2)          begin errors++; $display("FAIL basic_reads got=%0d exp=%0d", rd_count, r0 + 2); end
   endtask

   task automatic test_flush();
      int b0 = beats;
      push(16'h1234);
      repeat (4) @(negedge clk);
      checks++;
      if (m_valid !== 1'b0) begin errors++; $display("FAIL flush_hold got=%b exp=0", m_valid); end
      pulse_flush();
      wait_beat(b0, "flush");
      checks += 2;
      if (last_data !== 32'h0000_1234) begin errors++; $display("FAIL flush_data got=%h exp=00001234", last_data); end
      if (last_half !== 1'b1)          begin errors++; $display("FAIL flush_half got=%b exp=1", last_half); end
   endtask

   task automatic test_stall();
      int b0 = beats;
      int k = 0;
      m_ready = 1'b0;
      push(16'hCAFE);
      push(16'hBEEF);
      while (m_valid !== 1'b1 && k < 20) begin @(negedge clk); k++; end
      push(16'h7777);
      for (int i = 0; i < 5; i++) begin
         checks += 3;
         if (m_data !== 32'hBEEF_CAFE) begin errors++; $display("FAIL stall_data[%0d] got=%h exp=beefcafe", i, m_data); end
         if (m_valid !== 1'b1)         begin errors++; $display("FAIL stall_valid[%0d] got=%b exp=1", i, m_valid); end
         if (fifo_rd_en !== 1'b0)      begin errors++; $display("FAIL stall_rd_en[%0d] got=%b exp=0", i, fifo_rd_en); end
         @(negedge clk);
      end
      m_ready = 1'b1;
      wait_beat(b0, "stall");
      checks++;
      if (last_data !== 32'hBEEF_CAFE) begin errors++; $display("FAIL stall_beat got=%h exp=beefcafe", last_data); end
      repeat (4) @(negedge clk);
      pulse_flush();
      wait_beat(b0 + 1, "stall_tail");
      checks += 2;
      if (last_data !== 32'h0000_7777) begin errors++; $display("FAIL tail_data got=%h exp=00007777", last_data); end
      if (last_half !== 1'b1)          begin errors++; $display("FAIL tail_half got=%b exp=1", last_half); end
   endtask

   task automatic test_underflow();
      int b0 = beats;
      uf_at_read = rd_count + 1;
      push(16'h0A0A);
      push(16'hDEAD);
      repeat (6) @(negedge clk);
      checks += 3;
      if (m_valid !== 1'b0) begin errors++; $display("FAIL uf_valid got=%b exp=0", m_valid); end
      if (beats != b0)      begin errors++; $display("FAIL uf_beats got=%0d exp=%0d", beats, b0); end
      if (err_cnt !== 8'd1) begin errors++; $display("FAIL uf_err got=%0d exp=1", err_cnt); end
      uf_at_read = -1;
      push(16'h0001);
      wait_beat(b0, "uf");
      checks += 2;
      if (last_data !== 32'h0001_0A0A) begin errors++; $display("FAIL uf_data got=%h exp=00010a0a", last_data); end
      if (last_half !== 1'b0)          begin errors++; $display("FAIL uf_half got=%b exp=0", last_half); end
   endtask

   task automatic test_saturate();
      uf_man = 1'b1;
      repeat (300) @(negedge clk);
      uf_man = 1'b0;
      @(negedge clk);
      checks++;
      if (err_cnt !== 8'd255) begin errors++; $display("FAIL sat_err got=%0d exp=255", err_cnt); end
      uf_man = 1'b1;
      repeat (3) @(negedge clk);
      uf_man = 1'b0;
      @(negedge clk);
      checks++;
      if (err_cnt !== 8'd255) begin errors++; $display("FAIL sat_hold got=%0d exp=255", err_cnt); end
   endtask

   task automatic test_reset_mid();
      int b0;
      push(16'h0009);
      repeat (4) @(negedge clk);
      rst_n = 1'b0;
      @(negedge clk);
      checks += 2;
      if (err_cnt !== 8'd0) begin errors++; $display("FAIL rmid_err got=%0d exp=0", err_cnt); end
      if (m_valid !== 1'b0) begin errors++; $display("FAIL rmid_valid got=%b exp=0", m_valid); end
      rst_n = 1'b1;
      @(negedge clk);
      b0 = beats;
      push(16'h0002);
      push(16'h0003);
      wait_beat(b0, "rmid");
      checks += 2;
      if (last_data !== 32'h0003_0002) begin errors++; $display("FAIL rmid_data got=%h exp=00030002", last_data); end
      if (last_half !== 1'b0)          begin errors++; $display("FAIL rmid_half got=%b exp=0", last_half); end
   endtask

`ifdef PACKER_PARITY_EN
   task automatic test_parity();
      int k = 0;
      m_ready = 1'b0;
      push(16'h0001);
      repeat (4) @(negedge clk);
      pulse_flush();
      while (m_valid !== 1'b1 && k < 20) begin @(negedge clk); k++; end
      checks += 2;
      if (m_data !== 32'h0000_0001) begin errors++; $display("FAIL par_data got=%h exp=00000001", m_data); end
      if (m_parity !== 1'b1)        begin errors++; $display("FAIL par_bit got=%b exp=1", m_parity); end
      m_ready = 1'b1;
      repeat (3) @(negedge clk);
   endtask
`endif

   initial begin
      test_reset();
      test_basic();
      test_flush();
      test_stall();
      test_underflow();
      test_saturate();
      test_reset_mid();
`ifdef PACKER_PARITY_EN
      test_parity();
`endif
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule
